// File: rtl/sec_count_scan.sv
// Seconds counter front end for the two-digit seven-segment display: 1 Hz prescaler,
// BCD seconds 00-59 with run/pause/clear, a one-cycle minute pulse, and the digit-scan select.
module sec_count_scan #(
  parameter int TICK_DIV = 100_000_000,
  parameter int SCAN_W   = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [1:0] sel,
  output logic       min_tick
);

  localparam int               PRE_W   = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0]  pre;
  logic [SCAN_W-1:0] scan;
  logic              tick;
  logic [3:0]        ones_nxt;
  logic [3:0]        tens_nxt;
  logic              wrap;

  assign tick = en & (pre == PRE_MAX);

  // The >= comparisons force any stray non-BCD value back into range at the next tick.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    ones_nxt = sec_ones;
    tens_nxt = sec_tens;
    wrap     = 1'b0;
    if (tick) begin
      if (sec_ones >= 4'd9) begin
        ones_nxt = 4'd0;
        if (sec_tens >= 4'd5) begin
          tens_nxt = 4'd0;
          wrap     = 1'b1;
        end else begin
          tens_nxt = sec_tens + 4'd1;
        end
      end else begin
        ones_nxt = sec_ones + 4'd1;
      end
    end
  end

  // Pausing holds the prescaler, so a resumed second finishes its remaining cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      pre      <= '0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_tick <= 1'b0;
    end else if (clr) begin
      pre      <= '0;
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_tick <= 1'b0;
    end else begin
      if (en) begin
        pre <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
      end
      sec_ones <= ones_nxt;
      sec_tens <= tens_nxt;
      min_tick <= wrap;
    end
  end

  // Scan counter free-runs regardless of en/clr so the display never stops multiplexing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan <= '0;
    end else begin
      scan <= scan + 1'b1;
    end
  end

  assign sel = scan[SCAN_W-1 -: 2];

endmodule
